mdu_iter_divider: RTL and testbench

//   Iterative radix-2 restoring divider for the M-extension execute stage.
//   It is the inverse-direction companion of the multiplier's Wallace-tree/CLA product path.

---
 rtl/mdu_iter_divider.sv | 177 +++++++++++++++++
 tb/tb_mdu_iter_divider.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter_divider.sv
// ============================================================================
// mdu_iter_divider : radix-2 restoring divider for DIV/DIVU/REM/REMU
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mdu_iter_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            div_valid,
  output logic            div_ready,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int              c_cnt_w   = $clog2(XLEN + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(XLEN);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [XLEN-1:0] c_int_min = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [XLEN-1:0]    r_rem;
  logic [XLEN-1:0]    r_quo;
  logic [XLEN-1:0]    r_dvsr;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_is_rem;
  logic               r_qneg;
  logic               r_rneg;
  logic [XLEN-1:0]    r_result;

  logic               w_accept;
  logic               w_signed;
  logic               w_is_rem;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [XLEN-1:0]    w_a_abs;
  logic [XLEN-1:0]    w_b_abs;
  logic               w_div_zero;
  logic               w_overflow;
  logic               w_special;
  logic [XLEN-1:0]    w_special_res;
  logic [XLEN:0]      w_rem_sh;
  logic [XLEN:0]      w_trial;
  logic               w_trial_ok;
  logic [XLEN-1:0]    w_rem_nxt;
  logic [XLEN-1:0]    w_quo_nxt;
  logic [XLEN-1:0]    w_q_fin;
  logic [XLEN-1:0]    w_r_fin;
  logic [XLEN-1:0]    w_calc_res;
  logic               w_last_step;

  // ---------------------------------------------------------------- request
  assign div_ready = (r_state == IDLE) & ~flush;
  assign w_accept  = div_valid & div_ready;
  assign w_signed  = ~div_op[0];
  assign w_is_rem  = div_op[1];
  assign w_a_neg   = w_signed & dividend[XLEN-1];
  assign w_b_neg   = w_signed & divisor[XLEN-1];
  assign w_a_abs   = w_a_neg ? ({XLEN{1'b0}} - dividend) : dividend;
  assign w_b_abs   = w_b_neg ? ({XLEN{1'b0}} - divisor)  : divisor;

  // Special cases bypass the iteration and resolve at the accept edge
  assign w_div_zero = (divisor == {XLEN{1'b0}});
  assign w_overflow = w_signed & (dividend == c_int_min) & (divisor == {XLEN{1'b1}});
  assign w_special  = w_div_zero | w_overflow;

  always_comb begin
    w_special_res = {XLEN{1'b0}};
    if (w_div_zero) begin
      w_special_res = w_is_rem ? dividend : {XLEN{1'b1}};
    end else if (w_overflow) begin
      w_special_res = w_is_rem ? {XLEN{1'b0}} : dividend;
    end
  end

  // ---------------------------------------------------------------- iteration
  assign w_rem_sh   = {r_rem, r_quo[XLEN-1]};
  assign w_trial    = w_rem_sh - {1'b0, r_dvsr};
  assign w_trial_ok = ~w_trial[XLEN];
  assign w_rem_nxt  = w_trial_ok ? w_trial[XLEN-1:0] : w_rem_sh[XLEN-1:0];
  assign w_quo_nxt  = {r_quo[XLEN-2:0], w_trial_ok};
  assign w_last_step = (r_cnt == c_cnt_one);

  // Sign fix-up on the post-step values so the result lands on the final CALC edge
  assign w_q_fin    = r_qneg ? ({XLEN{1'b0}} - w_quo_nxt) : w_quo_nxt;
  assign w_r_fin    = r_rneg ? ({XLEN{1'b0}} - w_rem_nxt) : w_rem_nxt;
  assign w_calc_res = r_is_rem ? w_r_fin : w_q_fin;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_special ? DONE : CALC;
        end
      end
      CALC: begin
        if (w_last_step) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (flush) begin
      w_state_nxt = IDLE;
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem    <= {XLEN{1'b0}};
      r_quo    <= {XLEN{1'b0}};
      r_dvsr   <= {XLEN{1'b0}};
      r_cnt    <= {c_cnt_w{1'b0}};
      r_is_rem <= 1'b0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_result <= {XLEN{1'b0}};
    end else if (w_accept) begin
      r_rem    <= {XLEN{1'b0}};
      r_quo    <= w_a_abs;
      r_dvsr   <= w_b_abs;
      r_cnt    <= c_cnt_init;
      r_is_rem <= w_is_rem;
      r_qneg   <= w_a_neg ^ w_b_neg;
      r_rneg   <= w_a_neg;
      if (w_special) begin
        r_result <= w_special_res;
      end
    end else if ((r_state == CALC) && !flush) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt - c_cnt_one;
      if (w_last_step) begin
        r_result <= w_calc_res;
      end
    end
  end

  assign res_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign result    = r_result;

endmodule

`default_nettype wire

// File: tb/tb_mdu_iter_divider.sv
// ============================================================================
// tb_mdu_iter_divider : scoreboard bench for mdu_iter_divider (XLEN=32)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_mdu_iter_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        div_valid;
  logic        div_ready;
  logic [1:0]  div_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] result;
  logic        busy;

  mdu_iter_divider #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .div_op    (div_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .flush     (flush),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          lat;
    string       nm;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
    string       nm;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   seen  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: the first cycle a result is presented, pop and compare value and latency
  always @(negedge clk) begin
    if (!res_valid) begin
      seen = 1'b0;
    end else if (rst_n && !seen) begin
      exp_t e;
      seen = 1'b1;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result: got %h with nothing outstanding", result);
      end else begin
        e = sb.pop_front();
        if (result !== e.res) begin
          bad++;
          $display("FAIL %s value: got %h expected %h", e.nm, result, e.res);
        end
        total++;
        if ((cyc - e.acc) != e.lat) begin
          bad++;
          $display("FAIL %s latency: got %0d expected %0d", e.nm, cyc - e.acc, e.lat);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called a little after a rising edge with the DUT idle
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input int lat, input string nm, input bit track);
    div_op    = op;
    dividend  = a;
    divisor   = b;
    div_valid = 1'b1;
    #1;
    chk({nm, " div_ready"}, {31'b0, div_ready}, 32'd1);
    if (track) sb.push_back('{res, cyc, lat, nm});
    @(posedge clk);
    #2;
    div_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (busy && n < 200);
    if (busy) begin
      total++;
      bad++;
      $display("FAIL wait_idle: busy still %0b after %0d cycles", busy, n);
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!res_valid && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!res_valid) begin
      total++;
      bad++;
      $display("FAIL wait_valid: res_valid %0b after %0d cycles", res_valid, n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    div_valid = 1'b0;
    div_op    = 2'b00;
    dividend  = 32'd0;
    divisor   = 32'd0;
    flush     = 1'b0;
    res_ready = 1'b1;

    vecs.push_back('{OP_DIV,  32'd100,        32'd7,          32'd14,         33, "div_100_7"});
    vecs.push_back('{OP_REM,  32'd100,        32'd7,          32'd2,          33, "rem_100_7"});
    vecs.push_back('{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33, "div_m7_2"});
    vecs.push_back('{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33, "rem_m7_2"});
    vecs.push_back('{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33, "div_7_m2"});
    vecs.push_back('{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33, "rem_7_m2"});
    vecs.push_back('{OP_REM,  32'hFFFF_FFF8,  32'd2,          32'd0,          33, "rem_m8_2"});
    vecs.push_back('{OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1,  "divu_5_0"});
    vecs.push_back('{OP_REMU, 32'd5,          32'd0,          32'd5,          1,  "remu_5_0"});
    vecs.push_back('{OP_DIV,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1,  "div_m5_0"});
    vecs.push_back('{OP_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1,  "rem_m5_0"});
    vecs.push_back('{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  "div_ovf"});
    vecs.push_back('{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  "rem_ovf"});
    vecs.push_back('{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33, "remu_big"});

    #3;
    chk("reset res_valid", {31'b0, res_valid}, 32'd0);
    chk("reset busy",      {31'b0, busy},      32'd0);
    chk("reset div_ready", {31'b0, div_ready}, 32'd1);
    chk("reset result",    result,             32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #2;

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, vecs[i].nm, 1'b1);
      wait_idle();
    end

    // Backpressure, then a request on the cycle right after the handshake
    res_ready = 1'b0;
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 33, "divu_max_2", 1'b1);
    wait_valid();
    repeat (10) begin
      @(negedge clk);
      chk("hold res_valid", {31'b0, res_valid}, 32'd1);
      chk("hold result",    result,             32'h7FFF_FFFF);
      chk("hold div_ready", {31'b0, div_ready}, 32'd0);
    end
    @(posedge clk);
    #2;
    res_ready = 1'b1;
    @(posedge clk);
    #2;
    chk("handshake busy",      {31'b0, busy},      32'd0);
    chk("handshake res_valid", {31'b0, res_valid}, 32'd0);
    chk("handshake result",    result,             32'h7FFF_FFFF);
    issue(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, "divu_b2b", 1'b1);
    wait_idle();

    // Flush mid-iteration; a request alongside flush must be refused
    issue(OP_DIVU, 32'd1000, 32'd3, 32'd0, 0, "flushed", 1'b0);
    repeat (15) @(posedge clk);
    #2;
    chk("pre_flush busy", {31'b0, busy}, 32'd1);
    flush     = 1'b1;
    div_valid = 1'b1;
    div_op    = OP_DIVU;
    dividend  = 32'd9;
    divisor   = 32'd3;
    #1;
    chk("flush div_ready", {31'b0, div_ready}, 32'd0);
    @(posedge clk);
    #2;
    chk("flush busy",      {31'b0, busy},      32'd0);
    chk("flush res_valid", {31'b0, res_valid}, 32'd0);
    @(posedge clk);
    #2;
    chk("flush no_accept busy", {31'b0, busy}, 32'd0);
    flush     = 1'b0;
    div_valid = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    issue(OP_DIVU, 32'd9, 32'd3, 32'd3, 33, "divu_9_3", 1'b1);
    wait_idle();

    // Asynchronous reset mid-iteration
    issue(OP_DIV, 32'd100, 32'd7, 32'd0, 0, "reset_victim", 1'b0);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst res_valid", {31'b0, res_valid}, 32'd0);
    chk("async_rst busy",      {31'b0, busy},      32'd0);
    chk("async_rst div_ready", {31'b0, div_ready}, 32'd1);
    chk("async_rst result",    result,             32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #2;
    chk("post_rst busy", {31'b0, busy}, 32'd0);
    issue(OP_DIV, 32'd100, 32'd7, 32'd14, 33, "div_after_rst", 1'b1);
    wait_idle();
    repeat (3) @(posedge clk);
    #2;

    chk("scoreboard drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
